chip_reg_writer: RTL and testbench
==================================

// Module: chip_reg_writer
// PURPOSE
//  Sensor-side responder for the configuration FSM's write requests. Accepts row-bit, col-bit and
//  key-write strobes and serialises each onto the chip's row/col shift-register pins with a slow
//  generated shift clock, or pulses the chip key-load line. Returns a one-cycle o_chip_write_ready
//  after the requested chip operation completes. Sits between the config FSM and the chip pads.
// PARAMETERS
//  CLK_DIV    2  clk cycles per chip-clock phase (setup, high and hold each last CLK_DIV); range 1..2^NB_DIV-1
//  KEY_PULSE  4  clk cycles o_chip_key stays high per key write; range 1..2^NB_DIV-1
//  NB_DIV     8  width of the internal phase counter
// PORTS
//  clk                 in   1  system clock, rising edge
//  rst                 in   1  asynchronous, active-low reset
//  i_row_reg_write     in   1  request: shift i_row_reg_data into chip row register
//  i_row_reg_data      in   1  row bit, sampled with i_row_reg_write
//  i_col_reg_write     in   1  request: shift i_col_reg_data into chip col register
//  i_col_reg_data      in   1  col bit, sampled with i_col_reg_write
//  i_key_wren          in   1  request: pulse chip key-load line
//  o_chip_write_ready  out  1  one-cycle pulse: all accepted requests finished
//  o_busy              out  1  high from the cycle after acceptance until o_chip_write_ready, inclusive
//  o_chip_row_data     out  1  chip row shift-register data pin
//  o_chip_row_clk      out  1  chip row shift-register clock pin
//  o_chip_col_data     out  1  chip col shift-register data pin
//  o_chip_col_clk      out  1  chip col shift-register clock pin
//  o_chip_key          out  1  chip key-load strobe
//  o_overrun           out  1  sticky: request seen while busy (only with CHIP_WR_OVERRUN_EN)
// BEHAVIOUR
//  - Reset (rst=0): all outputs 0 asynchronously; FSM to IDLE; pending mask and latched bits cleared.
//  - All outputs registered. No combinational path from inputs to outputs.
//  - IDLE: any request strobe high on an edge is accepted. All strobes high on that edge are latched
//    into a pending mask {row,col,key}, together with both data bits. Go to SELECT.
//  - SELECT (0 cycles, folded into the acceptance/phase-end transition): next pending item in the
//    fixed order row -> col -> key. Nothing pending -> DONE.
//  - SHIFT_SETUP: drive the latched bit on the selected data pin; selected clk pin=0; CLK_DIV cycles.
//  - SHIFT_HIGH: selected clk pin=1; data held stable; CLK_DIV cycles.
//  - SHIFT_HOLD: clk pin=0; data held; CLK_DIV cycles; clear the pending bit; go to SELECT.
//  - KEY: o_chip_key=1 for KEY_PULSE cycles; clear key pending bit; go to SELECT.
//  - DONE: o_chip_write_ready=1 for exactly one cycle; go to IDLE. Requests on this edge are ignored.
//  - Data pins keep their last driven value between operations; they are not forced to 0.
//  - Latency (edges after the accepting edge to the ready cycle): row or col alone 3*CLK_DIV+1;
//    row+col 6*CLK_DIV+1; key alone KEY_PULSE+1; all three 6*CLK_DIV+KEY_PULSE+1.
//  - Only one clk pin toggles at a time; row and col clocks never high simultaneously.
//  - Requests arriving while o_busy=1 are dropped; the pending mask is never modified mid-operation.
//  - Phase counter counts down from CLK_DIV-1 (or KEY_PULSE-1) to 0; the phase ends at 0; no wrap.
//  - Reset mid-operation aborts immediately: clk pins and key return to 0; no ready pulse is issued.
// CONFIGURATION
//  - CHIP_WR_OVERRUN_EN defined: o_overrun is set on any request strobe while o_busy=1 or in DONE,
//    and stays set until reset.
//  - CHIP_WR_OVERRUN_EN undefined: o_overrun is tied 0 and no detection logic is generated.
//    Functional behaviour is otherwise identical.
// TESTING (CLK_DIV=2, KEY_PULSE=4)
//  - Row write, data=1 -> row_data=1 from edge 1; row_clk high during edges 3-4; ready at edge 7.
//    col pins and key stay 0 throughout.
//  - Row(0)+col(1) on the same edge -> row shift first (row_clk high edges 3-4), then col shift
//    (col_clk high edges 9-10); single ready pulse at edge 13.
//  - Key-only request -> o_chip_key high edges 1-4; ready at edge 5; busy high edges 1-5.
//  - Col request reasserted at edge 3 of a busy op -> ignored; one ready only.
//    o_overrun=1 with CHIP_WR_OVERRUN_EN defined, 0 without it.
//  - rst=0 asserted during SHIFT_HIGH -> row_clk=0 immediately; no ready pulse.
//    After release, a new request completes with normal latency.
//  - Row+col+key simultaneous -> ready at edge 17; row/col clocks never overlap with each other.

Source files
------------

// File: rtl/chip_reg_writer.sv
// chip_reg_writer: serialises row/col register bits and key-load pulses
// from the configuration FSM onto the sensor chip pads.
//
// Handshake: a request strobe (i_row_reg_write / i_col_reg_write / i_key_wren)
// is accepted only when the block is idle (o_busy=0 and not in DONE).
// All strobes high on the accepting edge are latched together. Completion is
// signalled by a single-cycle o_chip_write_ready, which is the last cycle o_busy is high.
// Strobes arriving while busy are dropped.
//
// Optional feature macro: CHIP_WR_OVERRUN_EN adds the sticky o_overrun flag.
// Without it o_overrun is tied low.
module chip_reg_writer #(
    parameter int CLK_DIV   = 2,
    parameter int KEY_PULSE = 4,
    parameter int NB_DIV    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_row_reg_write,
    input  logic       i_row_reg_data,
    input  logic       i_col_reg_write,
    input  logic       i_col_reg_data,
    input  logic       i_key_wren,
    output logic       o_chip_write_ready,
    output logic       o_busy,
    output logic       o_chip_row_data,
    output logic       o_chip_row_clk,
    output logic       o_chip_col_data,
    output logic       o_chip_col_clk,
    output logic       o_chip_key,
    output logic       o_overrun,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_KEY   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [NB_DIV-1:0] PHASE_LOAD = NB_DIV'(CLK_DIV - 1);
    localparam logic [NB_DIV-1:0] KEY_LOAD   = NB_DIV'(KEY_PULSE - 1);

    state_t            state;
    logic [NB_DIV-1:0] cnt;
    logic [2:0]        pending;   // {row, col, key}
    logic              row_bit;
    logic              col_bit;
    logic              cur_col;   // 0: row shift in progress, 1: col shift

    logic [2:0] req;
    logic       phase_end;
    logic [2:0] sel_src;          // mask the next item is chosen from
    logic       row_src;
    logic       col_src;
    logic       advance;          // acceptance or end of an item: pick the next one

    assign req         = {i_row_reg_write, i_col_reg_write, i_key_wren};
    assign phase_end   = (cnt == '0);
    assign o_dbg_state = state;

    // Selection source: fresh strobes on acceptance, else pending mask minus finished item
    always_comb begin
        sel_src = pending;
        row_src = row_bit;
        col_src = col_bit;
        advance = 1'b0;
        case (state)
            ST_IDLE: begin
                sel_src = req;
                row_src = i_row_reg_data;
                col_src = i_col_reg_data;
                advance = |req;
            end
            ST_HOLD: begin
                sel_src = cur_col ? (pending & 3'b101) : (pending & 3'b011);
                advance = phase_end;
            end
            ST_KEY: begin
                sel_src = pending & 3'b110;
                advance = phase_end;
            end
            default: ;
        endcase
    end

    // Main sequencer: phase timing, pad drive and completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_IDLE;
            cnt                <= '0;
            pending            <= '0;
            row_bit            <= 1'b0;
            col_bit            <= 1'b0;
            cur_col            <= 1'b0;
            o_chip_write_ready <= 1'b0;
            o_busy             <= 1'b0;
            o_chip_row_data    <= 1'b0;
            o_chip_row_clk     <= 1'b0;
            o_chip_col_data    <= 1'b0;
            o_chip_col_clk     <= 1'b0;
            o_chip_key         <= 1'b0;
        end else begin
            o_chip_write_ready <= 1'b0;
            case (state)
                ST_SETUP: begin
                    if (phase_end) begin
                        state <= ST_HIGH;
                        cnt   <= PHASE_LOAD;
                        if (cur_col) o_chip_col_clk <= 1'b1;
                        else         o_chip_row_clk <= 1'b1;
                    end else begin
                        cnt <= cnt - NB_DIV'(1);
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        state          <= ST_HOLD;
                        cnt            <= PHASE_LOAD;
                        o_chip_row_clk <= 1'b0;
                        o_chip_col_clk <= 1'b0;
                    end else begin
                        cnt <= cnt - NB_DIV'(1);
                    end
                end
                ST_HOLD: begin
                    if (!phase_end) cnt <= cnt - NB_DIV'(1);
                end
                ST_KEY: begin
                    if (phase_end) o_chip_key <= 1'b0;
                    else           cnt <= cnt - NB_DIV'(1);
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: ;
            endcase

            // Pick the next pending item in fixed order row -> col -> key
            if (advance) begin
                pending <= sel_src;
                row_bit <= row_src;
                col_bit <= col_src;
                o_busy  <= 1'b1;
                if (sel_src[2]) begin
                    state           <= ST_SETUP;
                    cur_col         <= 1'b0;
                    cnt             <= PHASE_LOAD;
                    o_chip_row_data <= row_src;
                end else if (sel_src[1]) begin
                    state           <= ST_SETUP;
                    cur_col         <= 1'b1;
                    cnt             <= PHASE_LOAD;
                    o_chip_col_data <= col_src;
                end else if (sel_src[0]) begin
                    state      <= ST_KEY;
                    cnt        <= KEY_LOAD;
                    o_chip_key <= 1'b1;
                end else begin
                    state              <= ST_DONE;
                    o_chip_write_ready <= 1'b1;
                end
            end
        end
    end

`ifdef CHIP_WR_OVERRUN_EN
    logic overrun_q;

    // Sticky flag: any strobe while busy (DONE included) was dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 overrun_q <= 1'b0;
        else if (o_busy && |req)  overrun_q <= 1'b1;
    end

    assign o_overrun = overrun_q;
`else
    assign o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_chip_reg_writer.sv
// Directed bench for chip_reg_writer with CLK_DIV=2, KEY_PULSE=4.
// Edge e of an operation is the e-th rising edge after the accepting edge;
// rec[e] holds the outputs as seen at that edge.
module tb_chip_reg_writer;

    logic       clk;
    logic       rst;
    logic       i_row_reg_write;
    logic       i_row_reg_data;
    logic       i_col_reg_write;
    logic       i_col_reg_data;
    logic       i_key_wren;
    logic       o_chip_write_ready;
    logic       o_busy;
    logic       o_chip_row_data;
    logic       o_chip_row_clk;
    logic       o_chip_col_data;
    logic       o_chip_col_clk;
    logic       o_chip_key;
    logic       o_overrun;
    logic [2:0] o_dbg_state;

    int tests = 0;
    int fails = 0;

    // bit 6 ready, 5 busy, 4 row_data, 3 row_clk, 2 col_data, 1 col_clk, 0 key
    logic [6:0] rec [0:31];

    localparam int B_RDY = 6;
    localparam int B_BSY = 5;
    localparam int B_RD  = 4;
    localparam int B_RC  = 3;
    localparam int B_CD  = 2;
    localparam int B_CC  = 1;
    localparam int B_KEY = 0;

    chip_reg_writer #(.CLK_DIV(2), .KEY_PULSE(4), .NB_DIV(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .i_row_reg_write    (i_row_reg_write),
        .i_row_reg_data     (i_row_reg_data),
        .i_col_reg_write    (i_col_reg_write),
        .i_col_reg_data     (i_col_reg_data),
        .i_key_wren         (i_key_wren),
        .o_chip_write_ready (o_chip_write_ready),
        .o_busy             (o_busy),
        .o_chip_row_data    (o_chip_row_data),
        .o_chip_row_clk     (o_chip_row_clk),
        .o_chip_col_data    (o_chip_col_data),
        .o_chip_col_clk     (o_chip_col_clk),
        .o_chip_key         (o_chip_key),
        .o_overrun          (o_overrun),
        .o_dbg_state        (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare one output bit over edges 1..n against "high exactly in lo..hi"
    task automatic chk_win(input string tag, input int bitn, input int n, input int lo, input int hi);
        logic [31:0] obs;
        logic [31:0] exp;
        obs = '0;
        exp = '0;
        for (int e = 1; e <= n; e++) begin
            obs[e] = rec[e][bitn];
            exp[e] = (e >= lo) && (e <= hi);
        end
        chk(tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issue one request, then record n edges; optionally re-raise the col strobe at edge inj_e
    task automatic run_op(input logic r, input logic rd, input logic c, input logic cd,
                          input logic k, input int n, input int inj_e);
        i_row_reg_write = r;
        i_row_reg_data  = rd;
        i_col_reg_write = c;
        i_col_reg_data  = cd;
        i_key_wren      = k;
        step();
        i_row_reg_write = 1'b0;
        i_row_reg_data  = 1'b0;
        i_col_reg_write = 1'b0;
        i_col_reg_data  = 1'b0;
        i_key_wren      = 1'b0;
        for (int e = 1; e <= n; e++) begin
            if (e == inj_e) begin
                i_col_reg_write = 1'b1;
                i_col_reg_data  = 1'b1;
            end
            @(posedge clk);
            rec[e] = {o_chip_write_ready, o_busy, o_chip_row_data, o_chip_row_clk,
                      o_chip_col_data, o_chip_col_clk, o_chip_key};
            #1;
            i_col_reg_write = 1'b0;
            i_col_reg_data  = 1'b0;
        end
    endtask

    initial begin
        int ready_cnt;
        int overlap;
        logic exp_ovr;

`ifdef CHIP_WR_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif

        // Reset
        rst             = 1'b0;
        i_row_reg_write = 1'b0;
        i_row_reg_data  = 1'b0;
        i_col_reg_write = 1'b0;
        i_col_reg_data  = 1'b0;
        i_key_wren      = 1'b0;
        #12;
        chk("reset_outputs", {25'd0, o_chip_write_ready, o_busy, o_chip_row_data, o_chip_row_clk,
                              o_chip_col_data, o_chip_col_clk, o_chip_key}, 32'd0);
        chk("reset_overrun", {31'd0, o_overrun}, 32'd0);
        chk("reset_state", {29'd0, o_dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        step();

        // Row write, data=1
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9, 0);
        chk_win("row1_row_data", B_RD, 9, 1, 9);
        chk_win("row1_row_clk", B_RC, 9, 3, 4);
        chk_win("row1_ready", B_RDY, 9, 7, 7);
        chk_win("row1_busy", B_BSY, 9, 1, 7);
        chk_win("row1_col_data", B_CD, 9, 0, 0);
        chk_win("row1_col_clk", B_CC, 9, 0, 0);
        chk_win("row1_key", B_KEY, 9, 0, 0);

        // Row(0) + col(1) together
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 14, 0);
        chk_win("rc_row_data", B_RD, 14, 0, 0);
        chk_win("rc_row_clk", B_RC, 14, 3, 4);
        chk_win("rc_col_clk", B_CC, 14, 9, 10);
        chk_win("rc_col_data", B_CD, 14, 7, 14);
        chk_win("rc_ready", B_RDY, 14, 13, 13);
        chk_win("rc_busy", B_BSY, 14, 1, 13);

        // Key only; data pins keep their previous values
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6, 0);
        chk_win("key_key", B_KEY, 6, 1, 4);
        chk_win("key_ready", B_RDY, 6, 5, 5);
        chk_win("key_busy", B_BSY, 6, 1, 5);
        chk_win("key_row_data", B_RD, 6, 0, 0);
        chk_win("key_col_data", B_CD, 6, 1, 6);
        chk_win("key_row_clk", B_RC, 6, 0, 0);

        // Col strobe reasserted at edge 3 of a busy row op: dropped
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10, 3);
        chk_win("ovr_row_clk", B_RC, 10, 3, 4);
        chk_win("ovr_col_clk", B_CC, 10, 0, 0);
        chk_win("ovr_ready", B_RDY, 10, 7, 7);
        chk_win("ovr_col_data", B_CD, 10, 1, 10);
        chk("ovr_flag", {31'd0, o_overrun}, {31'd0, exp_ovr});

        // Reset during SHIFT_HIGH
        i_row_reg_write = 1'b1;
        i_row_reg_data  = 1'b1;
        step();
        i_row_reg_write = 1'b0;
        i_row_reg_data  = 1'b0;
        step();
        step();
        chk("abort_pre_row_clk", {31'd0, o_chip_row_clk}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_row_clk", {31'd0, o_chip_row_clk}, 32'd0);
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_overrun", {31'd0, o_overrun}, 32'd0);
        ready_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            ready_cnt += int'(o_chip_write_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            ready_cnt += int'(o_chip_write_ready);
        end
        chk("abort_no_ready", ready_cnt, 0);
        chk("abort_idle_state", {29'd0, o_dbg_state}, 32'd0);

        // New request after reset completes with normal latency
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9, 0);
        chk_win("post_rst_ready", B_RDY, 9, 7, 7);
        chk_win("post_rst_row_clk", B_RC, 9, 3, 4);

        // Row(1) + col(1) + key together
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18, 0);
        chk_win("all_row_clk", B_RC, 18, 3, 4);
        chk_win("all_col_clk", B_CC, 18, 9, 10);
        chk_win("all_key", B_KEY, 18, 13, 16);
        chk_win("all_ready", B_RDY, 18, 17, 17);
        chk_win("all_busy", B_BSY, 18, 1, 17);
        chk_win("all_row_data", B_RD, 18, 1, 18);
        chk_win("all_col_data", B_CD, 18, 7, 18);
        overlap = 0;
        for (int e = 1; e <= 18; e++) overlap += int'(rec[e][B_RC] & rec[e][B_CC]);
        chk("all_no_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
